// File: rtl/cgia_bus_arbiter.sv
// Two-master Wishbone classic arbiter for the CGIA memory port: video fetcher (m0)
// and host/blitter (m1), with a watchdog that errors out cycles the slave never acks.
module cgia_bus_arbiter #(
  parameter int TIMEOUT     = 15,
  parameter int ROUND_ROBIN = 0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic [22:0] m0_adr_i,
  output logic [15:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [1:0]  m1_sel_i,
  input  logic [22:0] m1_adr_i,
  input  logic [15:0] m1_dat_i,
  output logic [15:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [1:0]  sel_o,
  output logic [22:0] adr_o,
  output logic [15:0] dat_o,
  input  logic [15:0] dat_i,
  input  logic        ack_i,
  output logic [1:0]  gnt_o
);

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] GNT0 = 2'b01;
  localparam logic [1:0] GNT1 = 2'b10;
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state, state_next;
  logic       last, last_next;
  logic [7:0] wd, wd_next;
  logic [1:0] err, err_next;
  logic       timeout;

  // Tie break: fixed priority favours m0; round robin favours the master not in last.
  function automatic logic [1:0] arbitrate(input logic c0, input logic c1, input logic lst);
    if (c0 && c1)
      return (ROUND_ROBIN != 0 && !lst) ? GNT1 : GNT0;
    else if (c0)
      return GNT0;
    else if (c1)
      return GNT1;
    else
      return IDLE;
  endfunction

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state <= IDLE;
      last  <= 1'b1;
      wd    <= 8'd0;
      err   <= 2'b00;
    end else begin
      state <= state_next;
      last  <= last_next;
      wd    <= wd_next;
      err   <= err_next;
    end
  end

  always_comb begin
    timeout    = (state != IDLE) && stb_o && !ack_i && (wd == WD_LAST);
    state_next = state;
    case (state)
      GNT0: begin
        if (timeout)       state_next = IDLE;
        else if (m0_cyc_i) state_next = GNT0;
        else               state_next = arbitrate(1'b0, m1_cyc_i, last);
      end
      GNT1: begin
        if (timeout)       state_next = IDLE;
        else if (m1_cyc_i) state_next = GNT1;
        else               state_next = arbitrate(m0_cyc_i, 1'b0, last);
      end
      default: state_next = arbitrate(m0_cyc_i, m1_cyc_i, last);
    endcase

    last_next = last;
    if (state == GNT0 && state_next != GNT0) last_next = 1'b0;
    if (state == GNT1 && state_next != GNT1) last_next = 1'b1;

    // Watchdog only counts strobe cycles the slave has left un-acked.
    if (timeout || state == IDLE || !stb_o || ack_i) wd_next = 8'd0;
    else                                              wd_next = wd + 8'd1;

    err_next = timeout ? state : 2'b00;
  end

  always_comb begin
    cyc_o = 1'b0;
    stb_o = 1'b0;
    we_o  = 1'b0;
    sel_o = 2'b00;
    adr_o = 23'd0;
    dat_o = 16'd0;
    case (state)
      GNT0: begin
        cyc_o = m0_cyc_i;
        stb_o = m0_stb_i;
        sel_o = 2'b11;
        adr_o = m0_adr_i;
      end
      GNT1: begin
        cyc_o = m1_cyc_i;
        stb_o = m1_stb_i;
        we_o  = m1_we_i;
        sel_o = m1_sel_i;
        adr_o = m1_adr_i;
        dat_o = m1_dat_i;
      end
      default: ;
    endcase
    m0_ack_o = (state == GNT0) && ack_i;
    m1_ack_o = (state == GNT1) && ack_i;
    m0_err_o = err[0];
    m1_err_o = err[1];
    m0_dat_o = dat_i;
    m1_dat_o = dat_i;
  end

  assign gnt_o = state;

endmodule

// File: tb/tb_cgia_bus_arbiter.sv
// Bench for cgia_bus_arbiter: a fixed-priority and a round-robin instance share stimulus
// and are compared every cycle against an ownership-level reference model.
module tb_cgia_bus_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        m0_cyc, m0_stb, m1_cyc, m1_stb, m1_we, s_ack;
  logic [22:0] m0_adr, m1_adr;
  logic [1:0]  m1_sel;
  logic [15:0] m1_dat, s_dat;

  logic [15:0] m0_rd [2];
  logic [15:0] m1_rd [2];
  logic        m0_ack [2];
  logic        m0_err [2];
  logic        m1_ack [2];
  logic        m1_err [2];
  logic        cyc [2];
  logic        stb [2];
  logic        we [2];
  logic [1:0]  sel [2];
  logic [22:0] adr [2];
  logic [15:0] wdat [2];
  logic [1:0]  gnt [2];

  cgia_bus_arbiter #(.TIMEOUT(15), .ROUND_ROBIN(0)) dut_fp (
    .clk_i(clk), .reset_i(reset_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_adr_i(m0_adr), .m0_dat_o(m0_rd[0]),
    .m0_ack_o(m0_ack[0]), .m0_err_o(m0_err[0]),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_rd[0]),
    .m1_ack_o(m1_ack[0]), .m1_err_o(m1_err[0]),
    .cyc_o(cyc[0]), .stb_o(stb[0]), .we_o(we[0]), .sel_o(sel[0]), .adr_o(adr[0]),
    .dat_o(wdat[0]), .dat_i(s_dat), .ack_i(s_ack), .gnt_o(gnt[0])
  );

  cgia_bus_arbiter #(.TIMEOUT(4), .ROUND_ROBIN(1)) dut_rr (
    .clk_i(clk), .reset_i(reset_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_adr_i(m0_adr), .m0_dat_o(m0_rd[1]),
    .m0_ack_o(m0_ack[1]), .m0_err_o(m0_err[1]),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_rd[1]),
    .m1_ack_o(m1_ack[1]), .m1_err_o(m1_err[1]),
    .cyc_o(cyc[1]), .stb_o(stb[1]), .we_o(we[1]), .sel_o(sel[1]), .adr_o(adr[1]),
    .dat_o(wdat[1]), .dat_i(s_dat), .ack_i(s_ack), .gnt_o(gnt[1])
  );

  // Reference model: who owns the bus (-1 none), who owned it last, stalled strobe count.
  int tmo [2] = '{15, 4};
  bit rr [2] = '{1'b0, 1'b1};
  int owner [2];
  int last_own [2];
  int stall [2];
  int err_who [2];
  logic [1:0] rr_exp [3] = '{2'b01, 2'b10, 2'b01};

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      owner[i] = -1; last_own[i] = 1; stall[i] = 0; err_who[i] = -1;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      logic own_cyc, own_stb, r0, r1;
      if (!reset_n) begin
        owner[i] = -1; last_own[i] = 1; stall[i] = 0; err_who[i] = -1;
        continue;
      end
      own_cyc = (owner[i] == 0) ? m0_cyc : (owner[i] == 1) ? m1_cyc : 1'b0;
      own_stb = (owner[i] == 0) ? m0_stb : (owner[i] == 1) ? m1_stb : 1'b0;
      err_who[i] = -1;
      if (owner[i] >= 0 && own_stb && !s_ack) stall[i]++;
      else stall[i] = 0;
      if (stall[i] == tmo[i]) begin
        err_who[i] = owner[i]; last_own[i] = owner[i]; owner[i] = -1; stall[i] = 0;
      end else if (owner[i] < 0 || !own_cyc) begin
        r0 = m0_cyc && owner[i] != 0;
        r1 = m1_cyc && owner[i] != 1;
        if (owner[i] >= 0) last_own[i] = owner[i];
        if (r0 && r1)  owner[i] = rr[i] ? 1 - last_own[i] : 0;
        else if (r0)   owner[i] = 0;
        else if (r1)   owner[i] = 1;
        else           owner[i] = -1;
      end
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 2; i++) begin
      logic [1:0]  eg;
      logic [44:0] es;
      logic [3:0]  et;
      eg = (owner[i] == 0) ? 2'b01 : (owner[i] == 1) ? 2'b10 : 2'b00;
      if (owner[i] == 0)      es = {m0_cyc, m0_stb, 1'b0, 2'b11, m0_adr, 16'h0000};
      else if (owner[i] == 1) es = {m1_cyc, m1_stb, m1_we, m1_sel, m1_adr, m1_dat};
      else                    es = '0;
      et = {owner[i] == 0 && s_ack, err_who[i] == 0, owner[i] == 1 && s_ack, err_who[i] == 1};
      check($sformatf("model_gnt%0d", i), 64'(gnt[i]), 64'(eg));
      check($sformatf("model_slave%0d", i),
            64'({cyc[i], stb[i], we[i], sel[i], adr[i], wdat[i]}), 64'(es));
      check($sformatf("model_term%0d", i),
            64'({m0_ack[i], m0_err[i], m1_ack[i], m1_err[i]}), 64'(et));
      check($sformatf("model_rdata%0d", i), 64'({m0_rd[i], m1_rd[i]}), 64'({s_dat, s_dat}));
    end
  endtask

  task automatic settle();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = '0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_sel = '0; m1_adr = '0; m1_dat = '0;
    s_ack = 1'b0; s_dat = 16'h5A5A;
    model_reset();

    // Reset held with a pending request: everything stays quiet.
    settle();
    check("rst_gnt", 64'(gnt[0]), 64'(2'b00));
    check("rst_ctl", 64'({cyc[0], stb[0], we[0], sel[0]}), 64'(0));
    check("rst_bus", 64'({adr[0], wdat[0]}), 64'(0));
    check("rst_term", 64'({m0_ack[0], m0_err[0], m1_ack[0], m1_err[0]}), 64'(0));
    tick();

    // Single m0 request.
    reset_n = 1'b1; m0_adr = 23'h7F8000;
    settle();
    check("idle_after_release", 64'(gnt[0]), 64'(2'b00));
    tick();
    s_ack = 1'b1;
    settle();
    check("m0_grant", 64'(gnt[0]), 64'(2'b01));
    check("m0_adr", 64'(adr[0]), 64'(23'h7F8000));
    check("m0_ack", 64'(m0_ack[0]), 64'(1));
    check("m1_ack_quiet", 64'(m1_ack[0]), 64'(0));
    tick();
    m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
    settle(); tick();

    // Tie from IDLE, then handover when m0 releases.
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    m1_we = 1'b1; m1_sel = 2'b10; m1_dat = 16'hBEEF; m1_adr = 23'h123456;
    settle(); tick();
    settle();
    check("tie_fixed", 64'(gnt[0]), 64'(2'b01));
    tick();
    m0_cyc = 1'b0; m0_stb = 1'b0;
    settle(); tick();
    settle();
    check("handover_gnt", 64'(gnt[0]), 64'(2'b10));
    check("handover_bus", 64'({we[0], sel[0], wdat[0]}), 64'({1'b1, 2'b10, 16'hBEEF}));
    tick();
    m1_cyc = 1'b0; m1_stb = 1'b0;
    settle(); tick();

    // Three consecutive round-robin ties.
    for (int k = 0; k < 3; k++) begin
      m0_cyc = 1'b1; m1_cyc = 1'b1;
      settle(); tick();
      settle();
      check($sformatf("rr_tie%0d", k), 64'(gnt[1]), 64'(rr_exp[k]));
      tick();
      m0_cyc = 1'b0; m1_cyc = 1'b0;
      settle(); tick();
    end

    // No preemption during an m1 burst; m0 follows with no idle cycle.
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0;
    settle(); tick();
    m0_cyc = 1'b1; m0_stb = 1'b1; s_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      check($sformatf("burst_gnt%0d", k), 64'(gnt[0]), 64'(2'b10));
      check($sformatf("burst_ack%0d", k), 64'({m0_ack[0], m1_ack[0]}), 64'(2'b01));
      tick();
    end
    m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
    settle();
    check("burst_release_gnt", 64'(gnt[0]), 64'(2'b10));
    tick();
    settle();
    check("burst_next_gnt", 64'(gnt[0]), 64'(2'b01));
    tick();
    m0_cyc = 1'b0; m0_stb = 1'b0;
    settle(); tick();

    // Watchdog: m1 strobes into a slave that never acks.
    m1_cyc = 1'b1; m1_stb = 1'b1;
    settle(); tick();
    for (int k = 0; k < 15; k++) begin
      settle();
      check($sformatf("wd_wait%0d", k), 64'({gnt[0], m1_err[0]}), 64'({2'b10, 1'b0}));
      tick();
    end
    m1_cyc = 1'b0; m1_stb = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1;
    settle();
    check("wd_err", 64'(m1_err[0]), 64'(1));
    check("wd_cyc_low", 64'({cyc[0], stb[0]}), 64'(0));
    check("wd_idle", 64'(gnt[0]), 64'(2'b00));
    tick();
    s_ack = 1'b1;
    settle();
    check("wd_err_one_cycle", 64'(m1_err[0]), 64'(0));
    check("wd_then_m0", 64'(gnt[0]), 64'(2'b01));
    tick();
    s_ack = 1'b0;
    settle(); tick();

    // Asynchronous reset in the middle of a GNT0 cycle.
    settle();
    check("pre_reset_cyc", 64'(cyc[0]), 64'(1));
    #2 reset_n = 1'b0;
    #1;
    check("async_cyc_drop", 64'(cyc[0]), 64'(0));
    check("async_gnt", 64'(gnt[0]), 64'(2'b00));
    model_reset();
    tick();
    reset_n = 1'b1; m1_cyc = 1'b1;
    settle();
    check("post_reset_idle", 64'({gnt[0], gnt[1]}), 64'(0));
    tick();
    settle();
    check("post_reset_last", 64'(gnt[1]), 64'(2'b01));
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      int ack_pct;
      case ((n / 600) % 3)
        0:       ack_pct = 50;
        1:       ack_pct = 5;
        default: ack_pct = 90;
      endcase
      if (!m0_cyc) m0_cyc = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 7) == 0) m0_cyc = 1'b0;
      if (!m1_cyc) m1_cyc = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 7) == 0) m1_cyc = 1'b0;
      m0_stb = m0_cyc && ($urandom_range(0, 3) != 0);
      m1_stb = m1_cyc && ($urandom_range(0, 3) != 0);
      m1_we  = 1'($urandom);
      m1_sel = 2'($urandom);
      m0_adr = 23'($urandom);
      m1_adr = 23'($urandom);
      m1_dat = 16'($urandom);
      s_dat  = 16'($urandom);
      s_ack  = ($urandom_range(0, 99) < ack_pct);
      settle(); tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
